prio_arbiter: RTL
=================

Name: prio_arbiter

Overview:
- Parametrised, registered priority arbiter; the next generation of the combinational 8-to-3 highest-bit priority encoder.
- Selects one of N requesters and presents the winner as an index and as a one-hot vector.
- Holds the grant under a valid/ready handshake until the consumer accepts it.
- Two modes: fixed priority, where the highest index wins as in the legacy encoder, and round-robin for fairness. Sits in front of shared-resource muxes.

Parameters:
- N, 8, number of requesters; N >= 2; non-power-of-two allowed.
- W, $clog2(N), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants service.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- grant_ready  input  1  consumer accepts the current grant.
- grant_valid  output  1  a grant is being presented.
- grant_idx  output  W  index of the granted requester.
- grant_onehot  output  N  one-hot form of grant_idx; all zero when grant_valid = 0.
- busy_all  output  1  registered flag; high when every req bit was high at the last arbitration.

Behaviour:
- Reset (asynchronous):
  - grant_valid = 0, grant_idx = 0, grant_onehot = 0, busy_all = 0.
  - Round-robin pointer ptr = N-1.
  - State = IDLE.
- State IDLE:
  - The block arbitrates every cycle.
  - If req is nonzero at edge t, grant_valid = 1 from edge t onward (one-cycle latency from req to registered grant). State moves to GRANT.
  - If req = 0, the block stays in IDLE with outputs zero.
- State GRANT:
  - grant_idx, grant_onehot and grant_valid are held stable while grant_ready = 0.
  - They stay held even if req changes or the granted bit drops; the grant cannot be revoked.
  - mode changes are ignored until the next arbitration point.
- Accept:
  - Occurs when grant_valid && grant_ready at an edge.
  - In round-robin mode, ptr updates to (grant_idx - 1) mod N, wrapping 0 -> N-1. In fixed mode, ptr is unchanged.
  - On the same edge, a fresh arbitration runs on the current req using the updated ptr.
    - If that result is nonzero, the new grant is registered (back-to-back grants, one per cycle) and state stays GRANT.
    - Otherwise grant_valid = 0 and state returns to IDLE.
- Fixed arbitration: the winner is the highest set index of req.
- Round-robin arbitration:
  - The search order is ptr, ptr-1, …, 0, N-1, …, ptr+1.
  - The winner is the first set bit in that order.
  - For N not a power of two, indices >= N never appear and the wrap goes to N-1, not 2^W-1.
- busy_all is updated only at arbitration points, registered together with the grant.
- Reset asserted mid-grant clears everything immediately; the pending grant is lost, not replayed.
- grant_ready while grant_valid = 0 is ignored.
- X on req is not guaranteed to be handled; the bench drives known values only.

Test Plan:
- Fixed mode, N=8:
  - req=8'b0010_0110, ready=0 -> grant_idx=5 and grant_onehot=8'b0010_0000 one cycle later.
  - Hold 5 cycles with req changed to 8'b1000_0000 -> grant unchanged.
  - Raise ready -> next grant_idx=7.
- Round-robin, N=8, req=8'hFF, ready=1 continuously:
  - grant_idx sequence 7,6,5,4,3,2,1,0,7, one grant per cycle.
  - busy_all=1 throughout.
- Round-robin, req=8'b1000_0001, ready=1 -> grants alternate 7,0,7,0.
- Legacy equivalence: fixed mode, ready=1, sweep req 1..255 -> every grant_idx equals the highest set bit of req.
  - Example: req=8'b0000_1100 gives 3.
- Reset mid-operation: assert rst while grant_valid=1 and grant_idx=4.
  - All outputs are 0 in the same cycle, without waiting for a clock edge.
  - After release with req=8'h10, round-robin mode -> grant_idx=4, since ptr was restored to 7.
- Parameter N=5, round-robin, req=5'b11111, ready=1 -> sequence 4,3,2,1,0,4; never 5-7.
  - req=0 -> grant_valid stays 0 and busy_all=0.

Source files
------------

// File: rtl/prio_arbiter.sv
// prio_arbiter: registered N-way priority arbiter with valid/ready grant handshake.
// mode = 0 selects fixed priority (highest index wins); mode = 1 selects round-robin,
// searching downward from a pointer that moves just below the last accepted winner.
module prio_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         grant_ready,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic         busy_all
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e         r_state;
    logic [W-1:0]   r_ptr;
    logic           r_valid;
    logic [W-1:0]   r_idx;
    logic [N-1:0]   r_onehot;
    logic           r_busy;

    logic           w_accept;
    logic [W-1:0]   w_ptr_next;
    logic [W-1:0]   w_cand;
    logic           w_found;
    logic [W-1:0]   w_win_idx;
    logic [N-1:0]   w_win_onehot;

    // Accept only counts while a grant is actually presented.
    assign w_accept = (r_state == StGrant) && grant_ready;

    // Pointer seen by an arbitration on this edge: moves below the accepted winner in RR mode.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_accept && mode) begin
            w_ptr_next = (r_idx == '0) ? W'(N - 1) : r_idx - W'(1);
        end
    end

    // Winner selection; loops run lowest-priority first so the highest-priority hit wins.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        if (!mode) begin
            for (int i = 0; i < int'(N); i++) begin
                if (req[i]) begin
                    w_found   = 1'b1;
                    w_win_idx = W'(i);
                end
            end
        end else begin
            // Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; k is the distance from ptr.
            for (int k = int'(N) - 1; k >= 0; k--) begin
                if (w_ptr_next >= W'(k)) begin
                    w_cand = w_ptr_next - W'(k);
                end else begin
                    w_cand = w_ptr_next + W'(int'(N) - k);
                end
                if (req[w_cand]) begin
                    w_found   = 1'b1;
                    w_win_idx = w_cand;
                end
            end
        end
    end

    // One-hot form of the winner, all zero when nothing is requested.
    always_comb begin
        w_win_onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_win_onehot[i] = w_found && (w_win_idx == W'(i));
        end
    end

    // Grant FSM: arbitrate every cycle in idle, hold in grant until accepted, then re-arbitrate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_ptr    <= W'(N - 1);
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_valid  <= w_found;
                    r_idx    <= w_win_idx;
                    r_onehot <= w_win_onehot;
                    r_busy   <= &req;
                    r_state  <= w_found ? StGrant : StIdle;
                end
                StGrant: begin
                    if (w_accept) begin
                        r_ptr    <= w_ptr_next;
                        r_valid  <= w_found;
                        r_idx    <= w_win_idx;
                        r_onehot <= w_win_onehot;
                        r_busy   <= &req;
                        r_state  <= w_found ? StGrant : StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign grant_valid  = r_valid;
    assign grant_idx    = r_idx;
    assign grant_onehot = r_onehot;
    assign busy_all     = r_busy;

endmodule
